bsg_manycore_endpoint_mem_arb: RTL

Arbitrates a tile's single-port synchronous data SRAM between the local core and remote requests leaving the standard endpoint's incoming interface (`in_v_o`/`in_yumi_i`/`in_data_o`/`in_mask_o`/`in_addr_o`/`in_we_o`). It returns read data, or a store-completion pulse, to the endpoint's `returning_data_i`/`returning_v_i` exactly one cycle after each remote grant. Local priority is the default, and a bounded starvation counter guarantees remote forward progress.

---
 rtl/bsg_manycore_endpoint_mem_arb_if.sv | 59 +++++
 rtl/bsg_manycore_endpoint_mem_arb.sv | 111 +++++++++++
 2 files changed

// File: rtl/bsg_manycore_endpoint_mem_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_manycore_endpoint_mem_arb_if                                         |
// | Remote/local request, response and SRAM signals for the tile memory arb. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bsg_manycore_endpoint_mem_arb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
);
  localparam int MASK_WIDTH = DATA_WIDTH >> 3;

  logic                      remote_v_i;
  logic                      remote_yumi_o;
  logic [DATA_WIDTH-1:0]     remote_data_i;
  logic [MASK_WIDTH-1:0]     remote_mask_i;
  logic [ADDR_WIDTH-1:0]     remote_addr_i;
  logic                      remote_we_i;
  logic [DATA_WIDTH-1:0]     returning_data_o;
  logic                      returning_v_o;

  logic                      local_v_i;
  logic [DATA_WIDTH-1:0]     local_data_i;
  logic [MASK_WIDTH-1:0]     local_mask_i;
  logic [ADDR_WIDTH-1:0]     local_addr_i;
  logic                      local_we_i;
  logic                      local_yumi_o;
  logic [DATA_WIDTH-1:0]     local_data_o;
  logic                      local_v_o;

  logic                      mem_v_o;
  logic                      mem_w_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_data_o;
  logic [MASK_WIDTH-1:0]     mem_mask_o;
  logic [DATA_WIDTH-1:0]     mem_data_i;

  // Arbiter side
  modport master (
    input  remote_v_i, remote_data_i, remote_mask_i, remote_addr_i, remote_we_i,
    input  local_v_i, local_data_i, local_mask_i, local_addr_i, local_we_i,
    input  mem_data_i,
    output remote_yumi_o, returning_data_o, returning_v_o,
    output local_yumi_o, local_data_o, local_v_o,
    output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o
  );

  // Endpoint / core / SRAM side
  modport slave (
    output remote_v_i, remote_data_i, remote_mask_i, remote_addr_i, remote_we_i,
    output local_v_i, local_data_i, local_mask_i, local_addr_i, local_we_i,
    output mem_data_i,
    input  remote_yumi_o, returning_data_o, returning_v_o,
    input  local_yumi_o, local_data_o, local_v_o,
    input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_manycore_endpoint_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_manycore_endpoint_mem_arb                                            |
// | Local-priority SRAM arbiter with bounded remote starvation.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bsg_manycore_endpoint_mem_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MAX_LOCAL_WINS = 4
) (
  input  wire logic                     clk_i,
  input  wire logic                     reset_i,
  bsg_manycore_endpoint_mem_arb_if.master bus
);
  localparam int MASK_WIDTH = DATA_WIDTH >> 3;
  localparam int CNT_WIDTH  = (MAX_LOCAL_WINS > 0) ? $clog2(MAX_LOCAL_WINS + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] C_MAX_WINS = CNT_WIDTH'(MAX_LOCAL_WINS);

  logic [CNT_WIDTH-1:0] r_starve_cnt;
  logic                 r_rem_rd;
  logic                 r_rem_wr;
  logic                 r_loc_rd;

  logic                      w_remote_pri;
  logic                      w_rem_gnt;
  logic                      w_loc_gnt;
  logic                      w_mem_w;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0]     w_mem_data;
  logic [MASK_WIDTH-1:0]     w_mem_mask;

  assign w_remote_pri = (r_starve_cnt >= C_MAX_WINS);

  // Grant depends only on request valids and the counter, never on mem_data_i
  always_comb begin
    w_rem_gnt = 1'b0;
    w_loc_gnt = 1'b0;
    if (!reset_i) begin
      if (w_remote_pri) begin
        if (bus.remote_v_i)     w_rem_gnt = 1'b1;
        else if (bus.local_v_i) w_loc_gnt = 1'b1;
      end else begin
        if (bus.local_v_i)       w_loc_gnt = 1'b1;
        else if (bus.remote_v_i) w_rem_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_mem_w    = 1'b0;
    w_mem_addr = '0;
    w_mem_data = '0;
    w_mem_mask = '0;
    if (w_rem_gnt) begin
      w_mem_w    = bus.remote_we_i;
      w_mem_addr = bus.remote_addr_i[MEM_ADDR_WIDTH-1:0];
      w_mem_data = bus.remote_data_i;
      w_mem_mask = bus.remote_mask_i;
    end else if (w_loc_gnt) begin
      w_mem_w    = bus.local_we_i;
      w_mem_addr = bus.local_addr_i[MEM_ADDR_WIDTH-1:0];
      w_mem_data = bus.local_data_i;
      w_mem_mask = bus.local_mask_i;
    end
  end

  assign bus.remote_yumi_o = w_rem_gnt;
  assign bus.local_yumi_o  = w_loc_gnt;
  assign bus.mem_v_o       = w_rem_gnt | w_loc_gnt;
  assign bus.mem_w_o       = w_mem_w;
  assign bus.mem_addr_o    = w_mem_addr;
  assign bus.mem_data_o    = w_mem_data;
  assign bus.mem_mask_o    = w_mem_mask;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_starve_cnt <= '0;
    end else if (w_rem_gnt || !bus.remote_v_i) begin
      r_starve_cnt <= '0;
    end else if (w_loc_gnt && (r_starve_cnt != C_MAX_WINS)) begin
      r_starve_cnt <= r_starve_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rem_rd <= 1'b0;
      r_rem_wr <= 1'b0;
      r_loc_rd <= 1'b0;
    end else begin
      r_rem_rd <= w_rem_gnt & ~bus.remote_we_i;
      r_rem_wr <= w_rem_gnt &  bus.remote_we_i;
      r_loc_rd <= w_loc_gnt & ~bus.local_we_i;
    end
  end

  // SRAM read data lands the cycle after the grant; steer it to the requester
  assign bus.returning_v_o    = r_rem_rd | r_rem_wr;
  assign bus.returning_data_o = r_rem_rd ? bus.mem_data_i : '0;
  assign bus.local_v_o        = r_loc_rd;
  assign bus.local_data_o     = r_loc_rd ? bus.mem_data_i : '0;

  // Upper address bits beyond the SRAM index are intentionally ignored
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0,
                           bus.remote_addr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                           bus.local_addr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};
endmodule
`default_nettype wire
